// File: rtl/sobel_stream_core_pkg.sv
// Shared constants for the Sobel stream core: magnitude mode encodings and default lane count.
// The optional threshold stage is selected with the SOBEL_THRESHOLD_EN macro.
package sobel_stream_core_pkg;

  localparam logic [1:0] SOBEL_MODE_SUM = 2'd0;
  localparam logic [1:0] SOBEL_MODE_MAX = 2'd1;
  localparam logic [1:0] SOBEL_MODE_GX  = 2'd2;
  localparam logic [1:0] SOBEL_MODE_GY  = 2'd3;

  localparam int NUM_SOBEL_ACCELERATORS = 16;

endpackage

// File: rtl/sobel_stream_core_lane.sv
// One Sobel lane: gradients (S1), absolute values (S2), combine + saturate (S3).
// With SOBEL_THRESHOLD_EN defined, S3 binarises the magnitude against thresh_p1.
module sobel_stream_core_lane
  import sobel_stream_core_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  input  logic [3*PIX_W-1:0] win1,
  input  logic [2*PIX_W-1:0] mid_ad,
  input  logic [3*PIX_W-1:0] win3,
  input  logic [1:0]         mode_p1,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIX_W-1:0]   thresh_p1,
`endif
  output logic [PIX_W-1:0]   pix_p2
);

  localparam int GW = PIX_W + 4;
  localparam logic [PIX_W-1:0] MAX = '1;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'({4'b0000, p});
  endfunction

  function automatic logic [GW-2:0] mag(input logic signed [GW-1:0] g);
    logic signed [GW-1:0] n;
    n = -g;
    return g[GW-1] ? n[GW-2:0] : g[GW-2:0];
  endfunction

  function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] m);
    return (m > {4'b0000, MAX}) ? MAX : m[PIX_W-1:0];
  endfunction

  logic [PIX_W-1:0] r1a, r1b, r1d, r2a, r2d, r3a, r3b, r3d;
  assign r1a = win1[2*PIX_W +: PIX_W];
  assign r1b = win1[PIX_W +: PIX_W];
  assign r1d = win1[0 +: PIX_W];
  assign r2a = mid_ad[PIX_W +: PIX_W];
  assign r2d = mid_ad[0 +: PIX_W];
  assign r3a = win3[2*PIX_W +: PIX_W];
  assign r3b = win3[PIX_W +: PIX_W];
  assign r3d = win3[0 +: PIX_W];

  logic signed [GW-1:0] gx_c, gy_c, gx_p0, gy_p0;
  logic [GW-2:0]        ax_p1, ay_p1;
  logic [GW-1:0]        sum_c, sel_c;
  logic [GW-2:0]        big_c;
  logic [PIX_W-1:0]     res_c;

  assign gx_c = (ext(r1a) + (ext(r1b) <<< 1) + ext(r1d)) - (ext(r3a) + (ext(r3b) <<< 1) + ext(r3d));
  assign gy_c = (ext(r1a) + (ext(r2a) <<< 1) + ext(r3a)) - (ext(r1d) + (ext(r2d) <<< 1) + ext(r3d));

  // S1 -> S2: signed gradients, then their magnitudes
  always_ff @(posedge clk) begin
    if (advance) begin
      gx_p0 <= gx_c;
      gy_p0 <= gy_c;
      ax_p1 <= mag(gx_p0);
      ay_p1 <= mag(gy_p0);
    end
  end

  always_comb begin
    sum_c = {1'b0, ax_p1} + {1'b0, ay_p1};
    big_c = (ax_p1 >= ay_p1) ? ax_p1 : ay_p1;
    case (mode_p1)
      SOBEL_MODE_SUM: sel_c = sum_c;
      SOBEL_MODE_MAX: sel_c = {1'b0, big_c};
      SOBEL_MODE_GX:  sel_c = {1'b0, ax_p1};
      default:        sel_c = {1'b0, ay_p1};
    endcase
    res_c = sat(sel_c);
`ifdef SOBEL_THRESHOLD_EN
    res_c = (res_c >= thresh_p1) ? MAX : '0;
`endif
  end

  // S3: output pixel, cleared by reset so a fresh stream starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_p2 <= '0;
    end else if (advance) begin
      pix_p2 <= res_c;
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// Pipelined Sobel core: NUM_LANES lanes, 3-cycle latency, valid/ready with full back-pressure.
// Defining SOBEL_THRESHOLD_EN adds the thresh port and binarised output.
module sobel_stream_core
  import sobel_stream_core_pkg::*;
#(
  parameter int NUM_LANES = NUM_SOBEL_ACCELERATORS,
  parameter int PIX_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(NUM_LANES+2)*PIX_W-1:0] in_row1,
  input  logic [(NUM_LANES+2)*PIX_W-1:0] in_row2,
  input  logic [(NUM_LANES+2)*PIX_W-1:0] in_row3,
  input  logic [1:0]                     in_mode,
  input  logic                           in_last,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIX_W-1:0]               thresh,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_LANES*PIX_W-1:0]     out_data,
  output logic                           out_last,
  output logic [15:0]                    beat_count
);

  logic       advance;
  logic       vld_p0, vld_p1, vld_p2;
  logic       last_p0, last_p1, last_p2;
  logic [1:0] mode_p0, mode_p1;
`ifdef SOBEL_THRESHOLD_EN
  logic [PIX_W-1:0] thresh_p0, thresh_p1;
`endif

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign advance   = !vld_p2 || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p2;
  assign out_last  = last_p2;

  // S1 -> S2 -> S3 control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p0 <= 1'b0;
      last_p1 <= 1'b0;
      last_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0  <= in_valid;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      last_p0 <= in_last;
      last_p1 <= last_p0;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= 16'd0;
    end else if (vld_p2 && out_ready) begin
      beat_count <= beat_count + 16'd1;
    end
  end

  // Per-beat side data; consumed by S3, so it only needs to reach S2
  always_ff @(posedge clk) begin
    if (advance) begin
      mode_p0   <= in_mode;
      mode_p1   <= mode_p0;
`ifdef SOBEL_THRESHOLD_EN
      thresh_p0 <= thresh;
      thresh_p1 <= thresh_p0;
`endif
    end
  end

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    sobel_stream_core_lane #(.PIX_W(PIX_W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .advance   (advance),
      .win1      (in_row1[c*PIX_W +: 3*PIX_W]),
      .mid_ad    ({in_row2[(c+2)*PIX_W +: PIX_W], in_row2[c*PIX_W +: PIX_W]}),
      .win3      (in_row3[c*PIX_W +: 3*PIX_W]),
      .mode_p1   (mode_p1),
`ifdef SOBEL_THRESHOLD_EN
      .thresh_p1 (thresh_p1),
`endif
      .pix_p2    (out_data[c*PIX_W +: PIX_W])
    );
  end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Scoreboard bench for sobel_stream_core; driver pushes expectations, monitor pops on each accepted output.
// Covers SOBEL_THRESHOLD_EN when that macro is defined for the build.
module tb_sobel_stream_core;

  localparam int NL = 16;
  localparam int PW = 8;
  localparam int RW = (NL + 2) * PW;
  localparam int OW = NL * PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] in_row1 = '0, in_row2 = '0, in_row3 = '0;
  logic [1:0]    in_mode = 2'd0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [15:0]   beat_count;
`ifdef SOBEL_THRESHOLD_EN
  logic [PW-1:0] thr = 8'd1;
`endif

  sobel_stream_core #(.NUM_LANES(NL), .PIX_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row1    (in_row1),
    .in_row2    (in_row2),
    .in_row3    (in_row3),
    .in_mode    (in_mode),
    .in_last    (in_last),
`ifdef SOBEL_THRESHOLD_EN
    .thresh     (thr),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .beat_count (beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    int            acc;
    bit            chk_lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   lat_on = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pp(input int m);
`ifdef SOBEL_THRESHOLD_EN
    return (m >= int'(thr)) ? 8'hFF : 8'h00;
`else
    return PW'(m);
`endif
  endfunction

  function automatic logic [RW-1:0] fill(input logic [PW-1:0] v);
    return {(NL+2){v}};
  endfunction

  function automatic logic [RW-1:0] px2(input logic [PW-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    r[2*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [OW-1:0] lanes3(input int x0, input int x1, input int x2);
    logic [OW-1:0] o;
    o = {NL{pp(0)}};
    o[0 +: PW]    = pp(x0);
    o[PW +: PW]   = pp(x1);
    o[2*PW +: PW] = pp(x2);
    return o;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [RW-1:0] r1, input logic [RW-1:0] r2, input logic [RW-1:0] r3,
                      input logic [1:0] m, input logic l, input logic [OW-1:0] e, input bit push);
    int   n;
    exp_t x;
    n = 0;
    in_row1 = r1; in_row2 = r2; in_row3 = r3;
    in_mode = m; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end else if (push) begin
      x.data = e; x.last = l; x.acc = cyc; x.chk_lat = lat_on;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops on every output handshake and checks hold-stability across stalls.
  logic [OW-1:0] held_d;
  logic          held_l;
  bit            held_v = 1'b0;
  exp_t          got;

  always @(negedge clk) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        chk("stall_valid", OW'(out_valid), OW'(1));
        chk("stall_data", out_data, held_d);
        chk("stall_last", OW'(out_last), OW'(held_l));
      end
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got %h required no beat", out_data);
        end else begin
          got = exp_q.pop_front();
          chk("out_data", out_data, got.data);
          chk("out_last", OW'(out_last), OW'(got.last));
          if (got.chk_lat) chk("latency", OW'(cyc - got.acc), OW'(3));
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held_d = out_data;
        held_l = out_last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RW-1:0] z;
    int            v;
    int            seen;
    z = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", OW'(out_valid), OW'(0));
    chk("reset_data", out_data, '0);
    chk("reset_count", OW'(beat_count), OW'(0));
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", OW'(in_ready), OW'(1));

    // Flat image: no edges anywhere
    send(fill(8'h80), fill(8'h80), fill(8'h80), 2'd0, 1'b1, {NL{pp(0)}}, 1'b1);
    drain();

    // Horizontal edge: Gx = 1020, Gy = 0; modes change beat to beat
    send(fill(8'hFF), z, z, 2'd0, 1'b0, {NL{pp(255)}}, 1'b1);
    send(fill(8'hFF), z, z, 2'd2, 1'b1, {NL{pp(255)}}, 1'b1);
    send(fill(8'hFF), z, z, 2'd3, 1'b0, {NL{pp(0)}}, 1'b1);

    // Pixel 2 column 15/10/5: lane0 (10,40), lane1 (20,0), lane2 (10,-40)
    send(px2(8'd15), px2(8'd10), px2(8'd5), 2'd0, 1'b0, lanes3(50, 20, 50), 1'b1);
    send(px2(8'd15), px2(8'd10), px2(8'd5), 2'd1, 1'b1, lanes3(40, 20, 40), 1'b1);
    send(px2(8'd15), px2(8'd10), px2(8'd5), 2'd2, 1'b0, lanes3(10, 20, 10), 1'b1);
    send(px2(8'd15), px2(8'd10), px2(8'd5), 2'd3, 1'b1, lanes3(40, 0, 40), 1'b1);
    drain();
    chk("count_after_directed", OW'(beat_count), OW'(8));

    // Stream of 8 beats with a 3-cycle output stall
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          v = 3 + 7 * i;
          send(fill(PW'(v)), z, z, 2'd2, (i % 3) == 0, {NL{pp(4 * v)}}, 1'b1);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("count_after_stream", OW'(beat_count), OW'(16));

`ifdef SOBEL_THRESHOLD_EN
    thr = 8'd50;
    send(px2(8'd49), z, z, 2'd2, 1'b0, {{13{8'h00}}, 8'h00, 8'hFF, 8'h00}, 1'b1);
    send(px2(8'd50), z, z, 2'd2, 1'b1, {{13{8'h00}}, 8'hFF, 8'hFF, 8'hFF}, 1'b1);
    drain();
    chk("count_after_thresh", OW'(beat_count), OW'(18));
`endif

    // Reset with three beats in flight and the output stalled
    out_ready = 1'b0;
    send(fill(8'hFF), z, z, 2'd0, 1'b1, '0, 1'b0);
    send(fill(8'hFF), z, z, 2'd0, 1'b1, '0, 1'b0);
    send(fill(8'hFF), z, z, 2'd0, 1'b1, '0, 1'b0);
    chk("inflight_valid", OW'(out_valid), OW'(1));
    #1 reset = 1'b1;
    #1;
    chk("midreset_valid", OW'(out_valid), OW'(0));
    chk("midreset_data", out_data, '0);
    chk("midreset_last", OW'(out_last), OW'(0));
    chk("midreset_count", OW'(beat_count), OW'(0));
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", OW'(in_ready), OW'(1));
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_beats_after_reset", OW'(seen), OW'(0));
    chk("count_after_reset", OW'(beat_count), OW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
